// File: rtl/hilo_seq.sv
// hilo_seq: HI/LO register file with a 3-cycle multiplier and a
// 32-iteration restoring divider, plus the pipeline stall request
// for instructions that touch HI/LO while an operation is running.
module hilo_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_rd_hl,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_SIGN = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sgn_q, sgn_d;      // signed multiply
    logic [31:0] a_q, a_d;          // raw rs operand
    logic [31:0] b_q, b_d;          // raw rt operand (multiplier)
    logic [63:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] quo_q, quo_d;      // dividend shifting out / quotient shifting in
    logic [31:0] dvs_q, dvs_d;      // divisor magnitude
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    // Operand magnitudes for the divider, taken straight from EX at accept.
    logic        div_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    assign div_signed = (ex_op == OP_DIV);
    assign abs_a      = (div_signed && ex_a[31]) ? (32'd0 - ex_a) : ex_a;
    assign abs_b      = (div_signed && ex_b[31]) ? (32'd0 - ex_b) : ex_b;

    // 64x64 multiply of extended operands; the low 64 bits are the exact
    // product for both signed and unsigned interpretations.
    logic [63:0] mul_a64;
    logic [63:0] mul_b64;
    logic [63:0] prod_full;
    assign mul_a64   = {{32{sgn_q & a_q[31]}}, a_q};
    assign mul_b64   = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod_full = mul_a64 * mul_b64;

    // One restoring step: shift in the next dividend bit and try a subtract.
    logic [32:0] rem_shift;
    logic [32:0] trial;
    assign rem_shift = {rem_q, quo_q[31]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    // Sign fixup results; divide by zero bypasses the fixup entirely.
    logic [31:0] q_final;
    logic [31:0] r_final;
    assign q_final = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (32'd0 - quo_q) : quo_q);
    assign r_final = dz_q ? a_q           : (rneg_q ? (32'd0 - rem_q) : rem_q);

    // Next-state and datapath computation for the whole sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid && !flush) begin
                    case (ex_op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = ex_a;
                            b_d     = ex_b;
                            sgn_d   = (ex_op == OP_MULT);
                            cnt_d   = 6'd0;
                            busy_d  = 1'b1;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = ex_a;
                            quo_d   = abs_a;
                            dvs_d   = abs_b;
                            rem_d   = 32'd0;
                            qneg_d  = div_signed & (ex_a[31] ^ ex_b[31]);
                            rneg_d  = div_signed & ex_a[31];
                            dz_d    = (ex_b == 32'd0);
                            cnt_d   = 6'd0;
                            busy_d  = 1'b1;
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = ex_a;
                        OP_MTLO: lo_d = ex_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd0) begin
                    prod_d = prod_full;
                end
                if (cnt_q == 6'd2) begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    cnt_d   = 6'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 6'd1;
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                hi_d    = r_final;
                lo_d    = q_final;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            prod_q  <= 64'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

    // Hold the front end only for HI/LO readers and HI/LO-writing ops.
    assign stall_out = busy_q & ex_valid &
                       (ex_rd_hl | ((ex_op != 3'b000) && (ex_op != 3'b111)));

endmodule
